// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin select arbiter.
//   sel_max(sel)  : highest requester index for a select width
//   arb_state_t   : arbiter FSM states (IDLE: Valid=0, GRANT: Valid=1)
//   BURST_CNT_W   : width of the burst counter (ARB_BURST_EN builds only)
package mux_pkg;

    localparam int BURST_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int sel_max(input int sel);
        return (1 << sel) - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   Req     : request vector, bit i = source i
//   ptr     : index the priority search starts from
//   win_idx : first requesting index at or after ptr (wraps)
//   win_any : at least one request is set
module rr_pick
    import mux_pkg::*;
#(
    parameter int SEL = 2
) (
    input  logic [(1<<SEL)-1:0] Req,
    input  logic [SEL-1:0]      ptr,
    output logic [SEL-1:0]      win_idx,
    output logic                win_any
);

    localparam int N = 1 << SEL;

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [SEL-1:0] w_off;

    // Concatenating Req with itself and shifting by ptr puts source ptr at
    // bit 0 with the wrapped sources following, so a plain lowest-set-bit
    // search gives the offset from ptr.
    assign w_dbl = {Req, Req};
    assign w_rot = N'(w_dbl >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = sel_max(SEL); i >= 0; i--) begin
            if (w_rot[i]) w_off = SEL'(i);
        end
    end

    // Offset addition wraps modulo N naturally in SEL bits.
    assign win_idx = ptr + w_off;
    assign win_any = |Req;

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the Select input of a packed-bus multiplexer.
//   clk, rst_n : clock (rising edge), async active-low reset
//   Req        : level request per source (N = 2**SEL)
//   Ready      : downstream accepts the current transfer
//   Select     : registered index of the granted source
//   Valid      : registered, Select is valid
//   Grant      : registered one-hot of Select while Valid, else zero
// Optional: define ARB_BURST_EN to let a granted source keep the grant for
// up to BURST consecutive transfers while it keeps requesting.
module rr_select_arbiter
    import mux_pkg::*;
#(
    parameter int SEL   = 2,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(1<<SEL)-1:0] Req,
    input  logic                Ready,
    output logic [SEL-1:0]      Select,
    output logic                Valid,
    output logic [(1<<SEL)-1:0] Grant
);

    localparam int N = 1 << SEL;

    if (BURST < 1 || BURST > 255) begin : g_burst_chk
        $error("BURST must be in 1..255");
    end

    arb_state_t      r_state;
    logic [SEL-1:0]  r_ptr;
    logic [SEL-1:0]  w_srch_ptr;
    logic [SEL-1:0]  w_win_idx;
    logic            w_win_any;
    logic            w_keep;

    // While granting, the only search that matters is the one taken on
    // acceptance, which starts just past the current Select.
    assign w_srch_ptr = (r_state == GRANT) ? Select + SEL'(1) : r_ptr;

    rr_pick #(.SEL(SEL)) u_pick (
        .Req     (Req),
        .ptr     (w_srch_ptr),
        .win_idx (w_win_idx),
        .win_any (w_win_any)
    );

`ifdef ARB_BURST_EN
    logic [BURST_CNT_W-1:0] r_bcnt;
    assign w_keep = Req[Select] &&
                    ({1'b0, r_bcnt} + 9'd1 < 9'(BURST));
`else
    assign w_keep = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            Select  <= '0;
            Valid   <= 1'b0;
            Grant   <= '0;
`ifdef ARB_BURST_EN
            r_bcnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_any) begin
                        r_state <= GRANT;
                        Select  <= w_win_idx;
                        Valid   <= 1'b1;
                        Grant   <= N'(1) << w_win_idx;
                    end
                end
                GRANT: begin
                    // Ready=0 holds everything: a presented transfer is
                    // never withdrawn, even if its request drops.
                    if (Ready) begin
                        if (w_keep) begin
`ifdef ARB_BURST_EN
                            r_bcnt <= r_bcnt + 1'b1;
`endif
                        end else begin
`ifdef ARB_BURST_EN
                            r_bcnt <= '0;
`endif
                            r_ptr <= w_srch_ptr;
                            if (w_win_any) begin
                                Select <= w_win_idx;
                                Grant  <= N'(1) << w_win_idx;
                            end else begin
                                r_state <= IDLE;
                                Valid   <= 1'b0;
                                Grant   <= '0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
module tb_rr_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] Req;
    logic       Ready;
    logic [1:0] Select;
    logic       Valid;
    logic [3:0] Grant;

    int vectors;
    int miscompares;

    rr_select_arbiter #(.SEL(2), .BURST(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Req    (Req),
        .Ready  (Ready),
        .Select (Select),
        .Valid  (Valid),
        .Grant  (Grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Valid=1 with the given Select; Grant must be its one-hot.
    task automatic chk_grant(input string tag, input logic [1:0] sel);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        chk({tag, "_valid"}, 32'(Valid), 32'd1);
        chk({tag, "_sel"}, 32'(Select), 32'(sel));
        chk({tag, "_grant"}, 32'(Grant), 32'(oh));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(Valid), 32'd0);
        chk({tag, "_grant"}, 32'(Grant), 32'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef ARB_BURST_EN
    localparam int NB = 7;
    logic [1:0] burst_exp [NB] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    localparam int NB = 4;
    logic [1:0] burst_exp [NB] = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif

    initial begin
        logic [1:0] rr_exp [5];
        logic [1:0] wrap_exp [3];
        rr_exp   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        wrap_exp = '{2'd3, 2'd0, 2'd3};
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        Req   = 4'b0000;
        Ready = 1'b0;
        #2;
        chk_idle("rst");
        chk("rst_sel", 32'(Select), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // No requests: stays idle.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle("noreq");
            chk("noreq_sel", 32'(Select), 32'd0);
        end

        // All requesting, Ready always: strict rotation, no bubbles.
        Req = 4'b1111;
        Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_grant("rr", rr_exp[i]);
        end
        Req = 4'b0000;
        step();
        chk_idle("rr_drain");           // ptr now 1

        // Single source held under backpressure, request dropped while held.
        Req = 4'b0100;
        Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_grant("hold", 2'd2);
        end
        Req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_grant("hold_drop", 2'd2);
        end
        Ready = 1'b1;
        step();
        chk_idle("hold_acc");           // ptr now 3
        Ready = 1'b0;

        // Move ptr to 1 by serving source 0, then wrap between 3 and 0.
        Req = 4'b0001;
        Ready = 1'b1;
        step();
        chk_grant("pre_wrap", 2'd0);
        Req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_grant("wrap", wrap_exp[i]);
        end
        Ready = 1'b0;
        step();
        chk_grant("wrap_hold", 2'd3);

        // Asynchronous reset between edges while holding Select=3.
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_sel", 32'(Select), 32'd0);
        step();
        rst_n = 1'b1;
        Req = 4'b1000;
        step();
        chk_grant("post_rst", 2'd3);
        Req = 4'b0000;
        Ready = 1'b1;
        step();
        chk_idle("post_rst_drain");     // ptr wraps to 0

        // Two sources: burst grouping with the macro, alternation without.
        Req = 4'b0011;
        for (int i = 0; i < NB; i++) begin
            step();
            chk_grant("burst", burst_exp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Round-robin arbiter that drives the `Select` input of the packed-bus multiplexer, choosing one of `2**SEL` requesters per transfer. It registers a selection, presents it with a valid/ready handshake toward the consumer of the multiplexer output, and rotates priority after every accepted transfer. It sits directly upstream of the multiplexer's select path, one arbiter per multiplexer instance.

## Interface
- `SEL`, 2, select width; number of requesters N = 2**SEL (must match the multiplexer's SEL)
- `BURST`, 4, max consecutive transfers per grant (used only with ARB_BURST_EN; range 1..255)
- `clk`  input  1  single clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `Req`  input  N  level request per source; bit i = source i (the multiplexer's DATAin word i)
- `Ready`  input  1  downstream accepts the current multiplexer output this cycle
- `Select`  output  SEL  registered index of granted source, wired to the multiplexer `Select`
- `Valid`  output  1  registered; `Select` and the multiplexer output are valid
- `Grant`  output  N  registered one-hot decode of `Select` while `Valid`=1, all-zero otherwise

## Operation
- States: IDLE (Valid=0), GRANT (Valid=1).
- Priority pointer `ptr` (SEL bits): the search starts at index `ptr` and wraps modulo N; the first set `Req` bit wins.
- IDLE: if any `Req` is set, load `Select` with the winner and go to GRANT. Otherwise stay in IDLE.
- GRANT, Ready=0: hold `Select`, `Valid` and `Grant` unchanged. This holds even if the granted `Req` drops, because a presented transfer is never withdrawn.
- GRANT, Ready=1 (transfer accepted):
  - `ptr` ← `Select`+1 (wraps N-1→0).
  - The next winner is searched from the new pointer in the same cycle, using the current `Req`.
  - If a winner exists, stay in GRANT with the new `Select` (back-to-back, no bubble). Otherwise go to IDLE.
- The next search masks nothing: if only the just-served source is requesting, it wins again.
- Ready while in IDLE is ignored.

## Timing
- Reset values: Select=0, Valid=0, Grant=0, ptr=0, state IDLE, burst counter 0.
- Latency: Req rising in cycle t → Valid=1 at the edge ending cycle t (visible in cycle t+1).
- Throughput: one transfer per cycle while requests are pending and Ready=1.
- `Select` is stable for the whole time Valid=1 && Ready=0.
- Reset asserted mid-transfer: all outputs clear immediately, asynchronously, and the held transfer is dropped. After reset deasserts, the first grant is searched from index 0.
- All outputs are registered; there is no combinational path from Req or Ready to any output.

## Configuration
- `ARB_BURST_EN` defined:
  - An 8-bit counter `bcnt` counts accepted transfers of the current grant.
  - On acceptance, if `Req[Select]` is still 1 and `bcnt`+1 < BURST, `Select` is kept, `ptr` is unchanged and `bcnt` increments.
  - Otherwise rotation proceeds as normal and `bcnt` ← 0.
- `ARB_BURST_EN` undefined: no counter, strict rotation after every transfer, and BURST is ignored.

## Structure
- Shared package `mux_pkg`:
  - a `sel_max(SEL)` constant function
  - the state enum typedef `arb_state_t` {IDLE, GRANT}
  - `BURST_CNT_W`=8
- Sub-module `rr_pick`: combinational. It takes `Req` and `ptr` and returns `win_idx` and `win_any`, using a double-width rotated priority search. The top level instantiates it once.

## Test plan
- Reset then Req=4'b0000 for 10 cycles → Valid=0, Select=0, Grant=0 throughout.
- Req=4'b1111, Ready=1 constant → Select sequence 0,1,2,3,0 on consecutive cycles, Valid=1 continuously from the cycle after Req rises.
- Req=4'b0100, Ready=0 for 5 cycles, then Req=0 while still Ready=0 → Select=2, Valid=1 held. Raise Ready → one accept, then Valid=0 next cycle.
- Req=4'b1001 with ptr at 1, Ready=1 → grants 3, then 0, then 3 (wrap across index boundary).
- Assert rst_n=0 asynchronously while Valid=1, Select=3 → Valid, Select, Grant go to 0 without waiting for a clock edge. After release, with Req=4'b1000 → Select=3 one cycle later.
- With ARB_BURST_EN, BURST=3, Req=4'b0011, Ready=1 → Select 0,0,0,1,1,1,0. Without the macro → 0,1,0,1.
